// File: rtl/ad1adc.sv
// Serial reader for the dual-channel PmodAD1: one shared frame clocks both AD7476A outputs in.
// Optional leading-bit check enabled with `define AD1ADC_LEADCHK_EN (sticky adcerr).
//
// state   | meaning
// IDLE    | adcsync high, waiting for adcen=1 and davadc=0
// SETUP   | adcsync low, shift registers and bit counter cleared
// SHIFT   | 16 bits x 2 phases, sample both sd inputs as adcsck rises
// DONE    | adcsync high, load outputs, raise adcdav
// WAIT    | hold adcdav until davadc is sampled high
// QUIET   | adcsync held high for QUIET cycles before IDLE
module ad1adc #(
   parameter int NBITS = 12,
   parameter int NLEAD = 4,
   parameter int QUIET = 2
) (
   input  logic             adcclk,
   input  logic             adcrstn,
   input  logic             adcen,
   input  logic             adcsd1,
   input  logic             adcsd2,
   output logic             adcsync,
   output logic             adcsck,
   output logic             adcdav,
   input  logic             davadc,
   output logic [NBITS-1:0] adcdata1,
   output logic [NBITS-1:0] adcdata2,
   output logic             adcerr
);

   localparam int FL = NLEAD + NBITS;
   localparam int QW = (QUIET > 1) ? $clog2(QUIET) : 1;
`ifdef AD1ADC_LEADCHK_EN
   localparam int SW = FL;
`else
   // Without the check the leading bits simply fall off the top of the register.
   localparam int SW = NBITS;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SHIFT, S_DONE, S_WAIT, S_QUIET
   } state_t;

   state_t          state;
   logic [4:0]      bitcnt;
   logic            phase;
   logic [QW-1:0]   qcnt;
   logic [SW-1:0]   sh1, sh2;

   always_ff @(posedge adcclk or negedge adcrstn) begin
      if (!adcrstn) begin
         state    <= S_IDLE;
         adcsync  <= 1'b1;
         adcsck   <= 1'b1;
         adcdav   <= 1'b0;
         adcdata1 <= '0;
         adcdata2 <= '0;
         bitcnt   <= '0;
         phase    <= 1'b0;
         qcnt     <= '0;
         sh1      <= '0;
         sh2      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               adcsync <= 1'b1;
               adcsck  <= 1'b1;
               if (adcen && !davadc) begin
                  state   <= S_SETUP;
                  adcsync <= 1'b0;
                  bitcnt  <= '0;
                  phase   <= 1'b0;
                  sh1     <= '0;
                  sh2     <= '0;
               end
            end
            S_SETUP: begin
               adcsck <= 1'b0;
               phase  <= 1'b0;
               state  <= S_SHIFT;
            end
            S_SHIFT: begin
               if (!phase) begin
                  adcsck <= 1'b1;
                  phase  <= 1'b1;
                  sh1    <= {sh1[SW-2:0], adcsd1};
                  sh2    <= {sh2[SW-2:0], adcsd2};
               end else if (bitcnt == 5'(FL-1)) begin
                  state   <= S_DONE;
                  adcsync <= 1'b1;
               end else begin
                  adcsck <= 1'b0;
                  phase  <= 1'b0;
                  bitcnt <= bitcnt + 5'd1;
               end
            end
            S_DONE: begin
               adcdata1 <= sh1[NBITS-1:0];
               adcdata2 <= sh2[NBITS-1:0];
               adcdav   <= 1'b1;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (davadc) begin
                  adcdav <= 1'b0;
                  qcnt   <= QW'(QUIET-1);
                  state  <= S_QUIET;
               end
            end
            S_QUIET: begin
               if (qcnt == '0) state <= S_IDLE;
               else            qcnt  <= qcnt - 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef AD1ADC_LEADCHK_EN
   always_ff @(posedge adcclk or negedge adcrstn) begin
      if (!adcrstn)
         adcerr <= 1'b0;
      else if (state == S_DONE && ((|sh1[FL-1:NBITS]) || (|sh2[FL-1:NBITS])))
         adcerr <= 1'b1;
   end
`else
   assign adcerr = 1'b0;
`endif

endmodule

// File: tb/tb_ad1adc.sv
// Bench for ad1adc: AD7476A-style converter models feed queued frames; a scoreboard of
// sent frames gives the expected samples, latency, handshake gaps and sticky error flag.
module tb_ad1adc;

   localparam int NB = 12;
   localparam int QT = 2;

   logic adcclk = 1'b0, adcrstn = 1'b0, adcen = 1'b0;
   logic adcsd1 = 1'b0, adcsd2 = 1'b0, davadc = 1'b0;
   logic adcsync, adcsck, adcdav, adcerr;
   logic [NB-1:0] adcdata1, adcdata2;

   ad1adc #(.NBITS(NB), .NLEAD(4), .QUIET(QT)) dut (
      .adcclk(adcclk), .adcrstn(adcrstn), .adcen(adcen),
      .adcsd1(adcsd1), .adcsd2(adcsd2), .adcsync(adcsync), .adcsck(adcsck),
      .adcdav(adcdav), .davadc(davadc), .adcdata1(adcdata1), .adcdata2(adcdata2),
      .adcerr(adcerr)
   );

   always #5 adcclk = ~adcclk;

   int nchk = 0, nfail = 0;
   logic [15:0] q1[$], q2[$], s1[$], s2[$];
   logic [15:0] cur1, cur2;
   logic [11:0] e1 = '0, e2 = '0;
   logic        eerr = 1'b0;
   int          idx = 15, nfall = 0;

   // Converter pair: first bit appears on chip-select fall, later bits after each sck fall.
   always @(negedge adcsync or negedge adcsck) begin
      if (adcsck === 1'b1) begin
         cur1 = (q1.size() > 0) ? q1.pop_front() : {4'b0, 12'($urandom_range(0, 4095))};
         cur2 = (q2.size() > 0) ? q2.pop_front() : {4'b0, 12'($urandom_range(0, 4095))};
         s1.push_back(cur1);
         s2.push_back(cur2);
         idx = 15;
         nfall = 0;
         adcsd1 = cur1[15];
         adcsd2 = cur2[15];
      end else begin
         nfall++;
         if (nfall > 1 && idx > 0) begin
            idx--;
            adcsd1 = cur1[idx];
            adcsd2 = cur2[idx];
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge adcclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int expgap(input int hold);
      return (QT + 1 - hold > 1) ? QT + 1 - hold : 1;
   endfunction

   task automatic deliver(input string tag);
      logic [15:0] f1, f2;
      check({tag, "_sb"}, 32'(s1.size() > 0), 1);
      if (s1.size() > 0) begin
         f1 = s1.pop_front();
         f2 = s2.pop_front();
         e1 = f1[11:0];
         e2 = f2[11:0];
`ifdef AD1ADC_LEADCHK_EN
         if (f1[15:12] != 4'h0 || f2[15:12] != 4'h0) eerr = 1'b1;
`endif
         check({tag, "_data1"}, 32'(adcdata1), 32'(e1));
         check({tag, "_data2"}, 32'(adcdata2), 32'(e2));
         check({tag, "_err"}, 32'(adcerr), 32'(eerr));
      end
   endtask

   task automatic wait_frame(input string tag);
      int n, lat, rises;
      logic psck, psync;
      n = 0;
      while (adcsync !== 1'b0 && n < 300) begin tick(); n++; end
      check({tag, "_start"}, 32'(n < 300), 1);
      lat = 0; rises = 0; psck = adcsck; psync = adcsync;
      while (adcdav !== 1'b1 && lat < 200) begin
         tick();
         lat++;
         if (psync === 1'b0 && psck === 1'b0 && adcsck === 1'b1) rises++;
         psck = adcsck; psync = adcsync;
      end
      check({tag, "_latency"}, lat, 34);
      check({tag, "_sck_rises"}, rises, 16);
      deliver(tag);
   endtask

   task automatic ack(input string tag, input int delay, input int hold);
      for (int i = 0; i < delay; i++) begin
         tick();
         check({tag, "_stable"}, {8'h0, adcdav, adcdata1, adcdata2}, {8'h0, 1'b1, e1, e2});
      end
      davadc = 1'b1;
      tick();
      check({tag, "_dav_fall"}, 32'(adcdav), 0);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, "_hold_sync"}, 32'(adcsync), 1);
      end
      davadc = 1'b0;
   endtask

   task automatic gap(input string tag, input int exp);
      int n;
      n = 0;
      while (adcsync !== 1'b0 && n < 20) begin tick(); n++; end
      check(tag, n, exp);
   endtask

   initial begin
      int d, h;
      logic seen;

      repeat (3) tick();
      check("rst_sync", 32'(adcsync), 1);
      check("rst_sck", 32'(adcsck), 1);
      check("rst_dav", 32'(adcdav), 0);
      check("rst_data1", 32'(adcdata1), 0);
      check("rst_data2", 32'(adcdata2), 0);
      check("rst_err", 32'(adcerr), 0);
      adcrstn = 1'b1;
      repeat (2) tick();
      check("idle_sync", 32'(adcsync), 1);

      q1.push_back(16'h0ABC); q2.push_back(16'h0123);
      adcen = 1'b1;
      wait_frame("single");
      check("single_abc", 32'(adcdata1), 32'h0ABC);
      check("single_123", 32'(adcdata2), 32'h0123);

      q1.push_back(16'h0FFF); q2.push_back(16'h0FFF);
      q1.push_back(16'h0000); q2.push_back(16'h0000);
      ack("hs", 10, 5);
      gap("hs_gap", expgap(5));
      wait_frame("ones");
      ack("ones", 0, 0);
      gap("b2b_gap", expgap(0));
      wait_frame("zeros");
      ack("zeros", 1, 0);
      gap("zeros_gap", expgap(0));

      for (int i = 0; i < 6; i++) begin
         wait_frame("rand");
         d = $urandom_range(0, 6);
         h = $urandom_range(0, 4);
         ack("rand", d, h);
         gap("rand_gap", expgap(h));
      end

      repeat (10) tick();
      adcen = 1'b0;
      d = 0;
      while (adcdav !== 1'b1 && d < 100) begin tick(); d++; end
      check("en_off_done", 32'(d < 100), 1);
      deliver("en_off");
      ack("en_off", 2, 0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (adcsync !== 1'b1) seen = 1'b1;
      end
      check("en_off_idle", 32'(seen), 0);
      adcen = 1'b1;
      gap("en_on_gap", 1);
      wait_frame("en_on");

      q1.push_back(16'h8ABC); q2.push_back(16'h0456);
      ack("en_on", 1, 0);
      gap("lead_gap", expgap(0));
      wait_frame("lead");
      check("lead_abc", 32'(adcdata1), 32'h0ABC);
      ack("lead", 0, 0);
      gap("clean_gap", expgap(0));
      wait_frame("clean");
      ack("clean", 0, 0);
      gap("rstmid_gap", expgap(0));

      repeat (15) tick();
      check("bit7_sck_low", 32'(adcsck), 0);
      adcrstn = 1'b0;
      #1;
      check("rstmid_sync", 32'(adcsync), 1);
      check("rstmid_sck", 32'(adcsck), 1);
      check("rstmid_dav", 32'(adcdav), 0);
      check("rstmid_data", {8'h0, adcdata1, adcdata2}, 0);
      check("rstmid_err", 32'(adcerr), 0);
      eerr = 1'b0;
      s1.delete(); s2.delete();
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (adcdav !== 1'b0) seen = 1'b1;
      end
      check("rstmid_no_dav", 32'(seen), 0);
      adcrstn = 1'b1;
      gap("post_rst_gap", 1);
      wait_frame("post_rst");
      ack("post_rst", 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
